// File: rtl/operand_input_pkg.sv
`default_nettype none
// ============================================================================
// Module   : operand_input_pkg
// Purpose  : Shared constants and types for the switch operand conditioner:
//            board-clock debounce default, synchroniser depth, handshake
//            state encoding and the raw switch "pressed" level.
// Revision : 1.0  initial release
// ============================================================================
package operand_input_pkg;

  // Board clock, and the debounce window derived from it (~10 ms).
  localparam int unsigned BOARD_CLK_HZ            = 27_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = BOARD_CLK_HZ / 100;

  // Flip-flop stages in each input synchroniser.
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  // Switches pull the pin low when pressed.
  localparam logic SW_PRESSED = 1'b0;

  // Producer handshake states.
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } hs_state_t;

endpackage : operand_input_pkg
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : debounce_bit
// Purpose  : One switch input: multi-stage synchroniser, inversion to
//            active-high, integrating debounce counter and stable flop,
//            plus a one-cycle chg pulse in the cycle the stable level moves.
// Revision : 1.0  initial release
// ============================================================================
module debounce_bit
  import operand_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT, // >= 2
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT      // >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic chg
);

  localparam int unsigned           CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]      TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt;

  // Synchroniser chain; resets to the released (high) pin level.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // Active-high view of the synchronised pin.
  assign s = (sync_q[SYNC_STAGES-1] == SW_PRESSED);

  // Debounce: accept s only after it differs from stable for the full window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
      chg    <= 1'b0;
    end else begin
      chg <= 1'b0;
      if (s == stable) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        stable <= s;
        cnt    <= '0;
        chg    <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule : debounce_bit
`default_nettype wire

// File: rtl/operand_input.sv
`default_nettype none
// ============================================================================
// Module   : operand_input
// Purpose  : Conditions two active-low switch operands (sync, debounce,
//            invert) and offers latest-value snapshots downstream over a
//            valid/ready handshake. Live debounced levels are also exposed.
// Revision : 1.0  initial release
// ============================================================================
module operand_input
  import operand_input_pkg::*;
#(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT, // >= 2
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT      // >= 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] IN_A,
  input  logic [WIDTH-1:0] IN_B,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [WIDTH-1:0] stable_a,
  output logic [WIDTH-1:0] stable_b
);

  localparam int unsigned NBITS = 2 * WIDTH;

  logic [NBITS-1:0] raw_all;
  logic [NBITS-1:0] stable_all;
  logic [NBITS-1:0] chg_all;
  logic             chg;

  hs_state_t        state, state_nx;
  logic [WIDTH-1:0] op_a_nx, op_b_nx;
  logic             dirty, dirty_nx;

  // Operand A occupies the low half, operand B the high half.
  assign raw_all  = {IN_B, IN_A};
  assign stable_a = stable_all[WIDTH-1:0];
  assign stable_b = stable_all[NBITS-1:WIDTH];
  assign chg      = |chg_all;

  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_debounce_bit (
      .clk    (sys_clk),
      .rst_n  (sys_rst_n),
      .raw    (raw_all[i]),
      .stable (stable_all[i]),
      .chg    (chg_all[i])
    );
  end

  // A snapshot is on offer exactly while the FSM is pending.
  assign op_valid = (state == PEND);

  // Handshake state, snapshot and dirty registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      dirty <= 1'b0;
    end else begin
      state <= state_nx;
      op_a  <= op_a_nx;
      op_b  <= op_b_nx;
      dirty <= dirty_nx;
    end
  end

  // Next-state: chg is registered, so stable already holds the new levels
  // in the chg cycle and a reload always captures post-update values.
  always_comb begin
    state_nx = state;
    op_a_nx  = op_a;
    op_b_nx  = op_b;
    dirty_nx = dirty;
    case (state)
      IDLE: begin
        if (chg) begin
          op_a_nx  = stable_a;
          op_b_nx  = stable_b;
          dirty_nx = 1'b0;
          state_nx = PEND;
        end
      end
      PEND: begin
        if (op_ready) begin
          if (dirty || chg) begin
            op_a_nx  = stable_a;
            op_b_nx  = stable_b;
            dirty_nx = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end else if (chg) begin
          dirty_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule : operand_input
`default_nettype wire

// File: tb/tb_operand_input.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_input
// Purpose  : Directed scoreboard bench for operand_input with a short
//            debounce window; a monitor checks every presented snapshot.
// Revision : 1.0  initial release
// ============================================================================
module tb_operand_input;

  localparam int unsigned WIDTH = 2;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic [WIDTH-1:0] IN_A, IN_B;
  logic [WIDTH-1:0] op_a, op_b, stable_a, stable_b;
  logic             op_valid, op_ready;

  int vectors = 0;
  int errors  = 0;

  logic [3:0] exp_q[$];   // {op_a, op_b}
  logic       last_valid = 1'b0;
  logic       last_ready = 1'b0;

  operand_input #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .IN_A      (IN_A),
    .IN_B      (IN_B),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .stable_a  (stable_a),
    .stable_b  (stable_b)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a new snapshot is presented when valid rises or follows an accept.
  always @(negedge sys_clk) begin
    logic [3:0] exp;
    if (op_valid === 1'b1 && (!last_valid || last_ready)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_snapshot: got a=%b b=%b expected none at %0t", op_a, op_b, $time);
      end else begin
        exp = exp_q.pop_front();
        if ({op_a, op_b} !== exp) begin
          errors++;
          $display("FAIL snapshot: got a=%b b=%b expected a=%b b=%b at %0t",
                   op_a, op_b, exp[3:2], exp[1:0], $time);
        end
      end
    end
    last_valid = op_valid;
    last_ready = op_ready;
  end

  initial begin
    sys_rst_n = 1'b0; IN_A = 2'b00; IN_B = 2'b00; op_ready = 1'b1;

    // Reset held 3 edges with all switches pressed.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outputs", {op_valid, op_a, op_b, stable_a, stable_b}, 8'h00);
    end
    sys_rst_n = 1'b1;
    exp_q.push_back({2'b11, 2'b11});
    tick();
    check("post_release_outputs", {op_valid, op_a, op_b, stable_a, stable_b}, 8'h00);
    repeat (4) tick();
    check("stable_a_before_6", {6'd0, stable_a}, 8'h00);
    tick();
    check("stable_a_at_6", {4'd0, stable_a, stable_b}, 8'h0F);
    tick();
    check("reset_valid_edge7", {7'd0, op_valid}, 8'h01);
    tick();
    check("reset_accepted", {7'd0, op_valid}, 8'h00);

    // Release everything.
    IN_A = 2'b11; IN_B = 2'b11;
    exp_q.push_back({2'b00, 2'b00});
    repeat (10) tick();

    // Clean press of A[0] with ready high.
    IN_A = 2'b10;
    exp_q.push_back({2'b01, 2'b00});
    repeat (5) tick();
    check("press_stable_pre", {6'd0, stable_a}, 8'h00);
    tick();
    check("press_stable_at_6", {6'd0, stable_a}, 8'h01);
    tick();
    check("press_valid", {5'd0, op_valid, op_a}, 8'h05);
    tick();
    check("press_one_cycle", {7'd0, op_valid}, 8'h00);

    // Glitch on B[0] one cycle short of the window.
    IN_B = 2'b10;
    repeat (3) tick();
    IN_B = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("glitch_quiet", {5'd0, op_valid, stable_b}, 8'h00);
    end

    // Back-pressure: two changes coalesce while pending.
    IN_A = 2'b11;
    exp_q.push_back({2'b00, 2'b00});
    repeat (10) tick();
    op_ready = 1'b0;
    IN_A = 2'b10;
    exp_q.push_back({2'b01, 2'b00});
    repeat (10) tick();
    check("bp_first_pending", {5'd0, op_valid, op_a}, 8'h05);
    IN_A = 2'b00;
    exp_q.push_back({2'b11, 2'b00});
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_held", {5'd0, op_valid, op_a}, 8'h05);
    end
    check("bp_stable_a", {6'd0, stable_a}, 8'h03);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check("bp_reload", {5'd0, op_valid, op_a}, 8'h07);
    op_ready = 1'b1;
    tick();
    check("bp_drained", {7'd0, op_valid}, 8'h00);

    // Accept coinciding with a stable_b update.
    op_ready = 1'b0;
    IN_A = 2'b10;
    exp_q.push_back({2'b01, 2'b00});
    repeat (10) tick();
    check("sim_pending", {7'd0, op_valid}, 8'h01);
    IN_B = 2'b10;
    repeat (6) tick();
    check("sim_stable_b", {6'd0, stable_b}, 8'h01);
    op_ready = 1'b1;
    exp_q.push_back({2'b01, 2'b01});
    tick();
    op_ready = 1'b0;
    check("sim_reload", {3'd0, op_valid, op_a, op_b}, 8'h15);
    tick();
    check("sim_held", {7'd0, op_valid}, 8'h01);
    op_ready = 1'b1;
    tick();
    check("sim_drained", {7'd0, op_valid}, 8'h00);

    // Reset in the middle of a press debounce.
    IN_A = 2'b00;
    repeat (4) tick();
    sys_rst_n = 1'b0;
    tick();
    check("midrst_cleared", {op_valid, op_a, op_b, stable_a, stable_b}, 8'h00);
    sys_rst_n = 1'b1;
    exp_q.push_back({2'b11, 2'b01});
    for (int i = 0; i < 5; i++) begin
      tick();
      check("midrst_no_valid", {5'd0, op_valid, stable_a}, 8'h00);
    end
    tick();
    check("midrst_stable", {3'd0, op_valid, stable_a, stable_b}, 8'h0D);
    tick();
    check("midrst_valid", {7'd0, op_valid}, 8'h01);
    repeat (4) tick();

    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_operand_input
`default_nettype wire

// File: doc/operand_input.md
Name: operand_input

Overview:
- Input-side conditioner for the switch-driven arithmetic/display path.
- Takes raw active-low switch/button levels for two 2-bit operands and synchronises, debounces and inverts them to active-high.
- Delivers operand snapshots to the downstream adder/display stage over a valid/ready handshake.
- This is the producer end of the operand interface the adder consumes. It replaces the adder's bare inversion of the pins with a clean, glitch-free, flow-controlled source.

Parameters:
- WIDTH, 2, bits per operand.
- DEBOUNCE_CYCLES, 270000, consecutive cycles a synchronised level must differ from the stable level before it is accepted (~10 ms at 27 MHz). Must be >= 2.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser. Must be >= 2.

Ports:
- sys_clk  input  1  single clock; all logic is rising-edge.
- sys_rst_n  input  1  synchronous, active-low reset, sampled on the sys_clk rising edge.
- IN_A  input  WIDTH  raw switch levels, operand A, active-low (0 = pressed), asynchronous.
- IN_B  input  WIDTH  raw switch levels, operand B, active-low, asynchronous.
- op_a  output  WIDTH  debounced operand A snapshot, active-high.
- op_b  output  WIDTH  debounced operand B snapshot, active-high.
- op_valid  output  1  snapshot on op_a/op_b is new and awaiting acceptance.
- op_ready  input  1  downstream accepts the snapshot when op_valid && op_ready on a rising edge.
- stable_a  output  WIDTH  live debounced level of A, active-high, no handshake (for LEDs).
- stable_b  output  WIDTH  live debounced level of B, active-high.

Behaviour:
- Reset (sys_rst_n = 0 at a rising edge):
  - All synchroniser flops load 1 (released).
  - All debounce counters clear to 0.
  - stable_a/stable_b = 0, op_a/op_b = 0, op_valid = 0, internal dirty flag = 0.
  - Reset asserted mid-debounce or mid-handshake aborts everything; no transfer is issued for pre-reset state.
- Synchroniser: each raw bit passes through SYNC_STAGES flops. The inverted output of the last stage is the synchronised active-high level s.
- Debounce, per bit and independent:
  - If s == stable: counter clears to 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= s and counter clears to 0.
  - Else: counter increments.
  - Any return of s to stable before terminal count clears the counter, so a glitch shorter than DEBOUNCE_CYCLES never propagates.
  - Latency: a raw level held steady updates stable exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges after the first edge that samples it.
- Change detect: "chg" is high in any cycle where any stable bit of A or B updates. Multiple bits updating on different cycles each raise chg.
- Handshake, 2-state FSM IDLE/PEND:
  - IDLE, chg = 1: next cycle op_a/op_b <= new stable values, op_valid <= 1, go to PEND.
  - PEND: op_a/op_b/op_valid are held constant until accepted.
  - PEND, chg = 1: set dirty = 1. The pending snapshot is not overwritten.
  - PEND, accept with dirty = 0: op_valid <= 0, go to IDLE.
  - PEND, accept with dirty = 1: reload op_a/op_b from current stable, op_valid stays 1, clear dirty, stay PEND. This gives back-to-back transfers.
  - PEND, accept and chg in the same cycle: treated as dirty = 1, reload with post-update stable values (the registered stable value visible on the next cycle).
  - op_ready while op_valid = 0 is ignored.
- Every transfer is latest-value; intermediate debounced states may be coalesced, but the final settled state is always eventually delivered.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package holds:
  - Default DEBOUNCE_CYCLES per board clock (27 MHz constant).
  - SYNC_STAGES default.
  - FSM state encoding IDLE = 1'b0, PEND = 1'b1.
  - Raw switch "pressed" level constant (0).
- One sub-module: debounce_bit. It contains the synchroniser, inversion, counter and stable flop for one input bit, with its own chg pulse output.
- operand_input instantiates 2*WIDTH debounce_bit copies, ORs their chg outputs, and contains the handshake FSM.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2, WIDTH = 2.
- Reset: hold sys_rst_n = 0 for 3 edges with IN_A = 2'b00, IN_B = 2'b00 -> all outputs 0 during and on the first edge after release; stable_a = 2'b11 exactly 6 edges after release.
- Clean press, op_ready = 1: IN_A 2'b11 -> 2'b10 held -> stable_a = 2'b01 after 6 edges; op_valid = 1 for one cycle on the next edge with op_a = 2'b01, op_b = 2'b00.
- Glitch rejection: IN_B[0] low for 3 cycles, then high -> stable_b, op_valid and op_b never change.
- Back-pressure: op_ready = 0; IN_A -> 2'b10 (A = 1), then after settle IN_A -> 2'b00 (A = 3) -> op_valid stays 1 with op_a = 2'b01 throughout. Raise op_ready for one edge -> op_a = 2'b11, op_valid still 1. Next accept -> op_valid = 0.
- Simultaneous accept + change: with the FSM in PEND, time a stable_b update to coincide with op_ready = 1 -> op_valid remains 1 and the reloaded op_b equals the new stable_b.
- Reset mid-debounce: assert sys_rst_n = 0 on counter = 2 of a press -> after release no op_valid until a full 6-edge debounce of the still-held level completes.
